fifo_wr_arb: RTL and testbench



---
 rtl/fifo_pkg.sv | 16 +
 rtl/rr_pick.sv | 27 ++
 rtl/fifo_wr_arb.sv | 96 +++++++++
 tb/tb_fifo_wr_arb.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO write-side blocks.
package fifo_pkg;
    localparam int unsigned FIFO_DATA_W = 8;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) r++;
        return r;
    endfunction

    // Index after i in a ring of n slots.
    function automatic int unsigned next_idx(input int unsigned i, input int unsigned n);
        return (i + 32'd1 >= n) ? 32'd0 : i + 32'd1;
    endfunction
endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set req bit at or after start, wrapping at N_REQ.
module rr_pick
    import fifo_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
)(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  start,
    output logic             found,
    output logic [ID_W-1:0]  idx
);
    int unsigned w_cand;

    always_comb begin
        found  = 1'b0;
        idx    = '0;
        w_cand = 32'(start);
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (!found && req[ID_W'(w_cand)]) begin
                found = 1'b1;
                idx   = ID_W'(w_cand);
            end
            w_cand = next_idx(w_cand, N_REQ);
        end
    end
endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ producers, with
// optional burst locking so a producer can push up to BURST words back to back.
module fifo_wr_arb
    import fifo_pkg::*;
#(
    parameter  int unsigned DATA_W = FIFO_DATA_W,
    parameter  int unsigned N_REQ  = 4,
    parameter  int unsigned BURST  = 1,
    localparam int unsigned ID_W   = (clog2(N_REQ) > 0) ? clog2(N_REQ) : 1
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] data,
    output logic [N_REQ-1:0]        gnt,
    input  logic                    full,
    output logic                    write,
    output logic [DATA_W-1:0]       datain,
    output logic [ID_W-1:0]         wid
);
    localparam int unsigned CNT_W = (clog2(BURST + 1) > 0) ? clog2(BURST + 1) : 1;

    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  r_owner;
    logic [CNT_W-1:0] r_cnt;
    logic             r_lock;

    logic             w_hold;
    logic             w_drop;
    logic [ID_W-1:0]  w_base;
    logic [ID_W-1:0]  w_start;
    logic             w_found;
    logic [ID_W-1:0]  w_idx;
    logic             w_grant;
    logic [ID_W-1:0]  w_k;
    logic [CNT_W-1:0] w_cnt_nxt;

    // A lock whose owner let go behaves as if the owner had just finished its burst.
    assign w_hold    = r_lock && req[r_owner];
    assign w_drop    = r_lock && !req[r_owner];
    assign w_base    = w_drop ? r_owner : r_ptr;
    assign w_start   = ID_W'(next_idx(32'(w_base), N_REQ));

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req   (req),
        .start (w_start),
        .found (w_found),
        .idx   (w_idx)
    );

    assign w_grant   = !reset && !full && (w_hold || w_found);
    assign w_k       = w_hold ? r_owner : w_idx;
    assign w_cnt_nxt = w_hold ? r_cnt + CNT_W'(1) : CNT_W'(1);

    always_comb begin
        gnt    = '0;
        datain = '0;
        wid    = '0;
        write  = w_grant;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (w_grant && (w_k == ID_W'(i))) begin
                gnt[i] = 1'b1;
                datain = data[i*DATA_W +: DATA_W];
            end
        end
        if (w_grant) wid = w_k;
    end

    // Arbitration state; frozen entirely while the FIFO is full.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr   <= ID_W'(N_REQ - 1);
            r_owner <= '0;
            r_cnt   <= '0;
            r_lock  <= 1'b0;
        end else if (!full) begin
            if (w_grant) begin
                r_owner <= w_k;
                r_cnt   <= w_cnt_nxt;
                if (w_cnt_nxt == CNT_W'(BURST)) begin
                    r_lock <= 1'b0;
                    r_ptr  <= w_k;
                end else begin
                    r_lock <= 1'b1;
                    r_ptr  <= w_base;
                end
            end else begin
                r_lock <= 1'b0;
                r_ptr  <= w_base;
            end
        end
    end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: a BURST=1 and a BURST=3 instance checked every cycle against a
// behavioural model, with directed literal checks and a FIFO-order scoreboard.
`timescale 1ns/1ps
module tb_fifo_wr_arb;
    localparam int NR    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 10;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR-1:0]    req    [2];
    logic [NR*DW-1:0] data   [2];
    logic             full   [2];
    logic [NR-1:0]    gnt    [2];
    logic             write  [2];
    logic [DW-1:0]    datain [2];
    logic [1:0]       wid    [2];

    int n_checks = 0;
    int n_fail   = 0;

    fifo_wr_arb #(.DATA_W(DW), .N_REQ(NR), .BURST(1)) u_dut0 (
        .clk(clk), .reset(reset), .req(req[0]), .data(data[0]), .gnt(gnt[0]),
        .full(full[0]), .write(write[0]), .datain(datain[0]), .wid(wid[0])
    );
    fifo_wr_arb #(.DATA_W(DW), .N_REQ(NR), .BURST(3)) u_dut1 (
        .clk(clk), .reset(reset), .req(req[1]), .data(data[1]), .gnt(gnt[1]),
        .full(full[1]), .write(write[1]), .datain(datain[1]), .wid(wid[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%0h, want 0x%0h at %0t", name, d, act, exp, $time);
        end
    endtask

    function automatic int burst_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic bit has_req(input logic [NR-1:0] r, input int i);
        return r[i[1:0]] === 1'b1;
    endfunction

    // Behavioural model: last owner, current burst owner and its word count.
    int            m_ptr   [2];
    int            m_owner [2];
    int            m_cnt   [2];
    bit            m_lock  [2];
    int            m_k;
    int            m_base;
    logic [NR-1:0] m_req;
    logic [31:0]   m_data;

    logic [NR-1:0] cap_gnt   [2];
    logic          cap_write [2];
    logic [DW-1:0] cap_din   [2];
    logic [1:0]    cap_wid   [2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            m_req  = req[d];
            m_data = data[d];
            m_k    = -1;
            if (!reset && !full[d]) begin
                if (m_lock[d] && has_req(m_req, m_owner[d])) begin
                    m_k = m_owner[d];
                end else begin
                    m_base = m_lock[d] ? m_owner[d] : m_ptr[d];
                    for (int s = 1; s <= NR; s++)
                        if (m_k < 0 && has_req(m_req, (m_base + s) % NR)) m_k = (m_base + s) % NR;
                end
            end
            chk("gnt", d, 32'(gnt[d]), (m_k < 0) ? 32'd0 : (32'd1 << m_k));
            chk("write", d, 32'(write[d]), (m_k >= 0) ? 32'd1 : 32'd0);
            chk("datain", d, 32'(datain[d]), (m_k < 0) ? 32'd0 : ((m_data >> (8 * m_k)) & 32'hFF));
            chk("wid", d, 32'(wid[d]), (m_k < 0) ? 32'd0 : 32'(m_k));
            chk("write_while_full", d, 32'(write[d] & full[d]), 32'd0);
            cap_gnt[d]   = gnt[d];
            cap_write[d] = write[d];
            cap_din[d]   = datain[d];
            cap_wid[d]   = wid[d];
            if (reset) begin
                m_ptr[d]   = NR - 1;
                m_owner[d] = 0;
                m_cnt[d]   = 0;
                m_lock[d]  = 1'b0;
            end else if (!full[d]) begin
                if (m_lock[d] && !has_req(m_req, m_owner[d])) begin
                    m_lock[d] = 1'b0;
                    m_ptr[d]  = m_owner[d];
                end
                if (m_k >= 0) begin
                    if (m_lock[d] && m_k == m_owner[d]) m_cnt[d]++;
                    else begin
                        m_owner[d] = m_k;
                        m_cnt[d]   = 1;
                    end
                    if (m_cnt[d] == burst_of(d)) begin
                        m_lock[d] = 1'b0;
                        m_ptr[d]  = m_k;
                    end else begin
                        m_lock[d] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic cyc(input bit rst, input logic [NR-1:0] r, input bit f);
        @(posedge clk);
        #1;
        reset = rst;
        for (int d = 0; d < 2; d++) begin
            req[d]  = r;
            full[d] = f;
            data[d] = 32'hD3C2B1A0;
        end
        @(negedge clk);
        #1;
    endtask

    // Literal expectation on one instance; w < 0 means no write this cycle.
    task automatic lit(input string name, input int d, input int w);
        chk({name, "_write"}, d, 32'(write[d]), (w >= 0) ? 32'd1 : 32'd0);
        chk({name, "_wid"}, d, 32'(wid[d]), (w >= 0) ? 32'(w) : 32'd0);
        if (w >= 0) chk({name, "_din"}, d, 32'(datain[d]), 32'hA0 + 32'h11 * 32'(w));
    endtask

    int exp_rr_b1 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp_rr_b3 [8] = '{0, 0, 0, 1, 1, 1, 2, 2};
    int exp_pr_b1 [9] = '{0, 2, 0, 2, 0, 2, 0, 2, 0};
    int exp_pr_b3 [9] = '{0, 0, 0, 2, 2, 2, 0, 0, 0};

    logic [9:0] fq [2][$];
    logic [7:0] pq [8][$];
    logic [5:0] pseq [8];
    logic [9:0] e;
    int         pi;
    int         accepted;

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req[d]  = '0;
            full[d] = 1'b0;
            data[d] = '0;
        end

        cyc(1, 4'b1111, 0);
        cyc(1, 4'b1111, 0);
        lit("reset", 0, -1);
        lit("reset", 1, -1);

        // All four requesting continuously.
        for (int c = 0; c < 8; c++) begin
            cyc(0, 4'b1111, 0);
            lit("rr_all", 0, exp_rr_b1[c]);
            lit("rr_all", 1, exp_rr_b3[c]);
        end

        // Two sparse requesters.
        cyc(1, 4'b0101, 0);
        for (int c = 0; c < 9; c++) begin
            cyc(0, 4'b0101, 0);
            lit("pair", 0, exp_pr_b1[c]);
            lit("pair", 1, exp_pr_b3[c]);
        end

        // Owner drops mid-burst: next requester served with no bubble.
        cyc(1, 4'b0000, 0);
        cyc(0, 4'b0101, 0);
        lit("drop", 1, 0);
        cyc(0, 4'b0101, 0);
        lit("drop", 1, 0);
        cyc(0, 4'b0100, 0);
        lit("drop_next", 1, 2);
        cyc(0, 4'b0111, 0);
        lit("drop_keep", 1, 2);

        // FIFO full in the middle of a burst owned by producer 1.
        cyc(1, 4'b0000, 0);
        cyc(0, 4'b0010, 0);
        lit("full_pre", 1, 1);
        for (int c = 0; c < 3; c++) begin
            cyc(0, 4'b1111, 1);
            lit("full_hold", 0, -1);
            lit("full_hold", 1, -1);
        end
        cyc(0, 4'b1111, 0);
        lit("full_resume", 1, 1);
        cyc(0, 4'b1111, 0);
        lit("full_resume", 1, 1);
        cyc(0, 4'b1111, 0);
        lit("full_after", 1, 2);

        // Reset in the middle of a burst.
        cyc(1, 4'b1111, 0);
        cyc(0, 4'b1111, 0);
        lit("rst_mid_pre", 1, 0);
        cyc(0, 4'b1111, 0);
        lit("rst_mid_pre", 1, 0);
        cyc(1, 4'b1111, 0);
        lit("rst_mid", 0, -1);
        lit("rst_mid", 1, -1);
        cyc(0, 4'b1111, 0);
        lit("rst_mid_post", 0, 0);
        lit("rst_mid_post", 1, 0);

        // Random producers feeding a depth-10 FIFO with random reads.
        cyc(0, 4'b0000, 0);
        for (int i = 0; i < 8; i++) pseq[i] = '0;
        accepted = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if ($urandom_range(0, 2) == 0 && fq[d].size() > 0) begin
                    e  = fq[d].pop_front();
                    pi = d * 4 + int'(e[9:8]);
                    if (pq[pi].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL sb_unexpected dut%0d: got word 0x%0h from producer %0d, want none", d, e[7:0], e[9:8]);
                    end else begin
                        chk("sb_order", d, 32'(e[7:0]), 32'(pq[pi].pop_front()));
                    end
                end
                if (cap_write[d]) fq[d].push_back({cap_wid[d], cap_din[d]});
                for (int i = 0; i < NR; i++) begin
                    if (cap_gnt[d][i]) begin
                        pq[d * 4 + i].push_back({i[1:0], pseq[d * 4 + i]});
                        pseq[d * 4 + i] = pseq[d * 4 + i] + 6'd1;
                        accepted++;
                        req[d][i] = ($urandom_range(0, 1) == 0);
                    end else if (req[d][i]) begin
                        if ($urandom_range(0, 15) == 0) req[d][i] = 1'b0;
                    end else begin
                        req[d][i] = ($urandom_range(0, 1) == 0);
                    end
                    data[d][i * 8 +: 8] = {i[1:0], pseq[d * 4 + i]};
                end
                full[d] = (fq[d].size() >= DEPTH);
            end
        end
        @(negedge clk);
        chk("progress", 0, 32'(accepted > 500), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
